regfile_mp: RTL and testbench

Parametrised multi-port integer register file for the RV32i single-cycle core, and the successor to the fixed two-read-port register file. It provides a configurable number of combinational read ports and one synchronous write port, with optional write-through bypass and a hardwired-zero x0. A sequential clear engine zeroes every register after reset, or on request, and gates the core through a `ready` output.

---
 rtl/regfile_mp.sv | 120 ++++++++++++
 tb/tb_regfile_mp.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port register file with combinational read
// ports, one synchronous write port, optional write-through bypass, a
// hardwired-zero x0 and a sequential clear engine that gates the core via ready.
module regfile_mp #(
    parameter int XLEN     = 32,
    parameter int NREGS    = 32,
    parameter int NRD      = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(NREGS)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                clr,
    output logic                ready,
    input  logic                we,
    input  logic [AW-1:0]       wraddr,
    input  logic [XLEN-1:0]     wrdata,
    input  logic [NRD*AW-1:0]   rs,
    output logic [NRD*XLEN-1:0] rdout,
    output logic                wr_drop
);

    typedef enum logic {
        CLEAR = 1'b0,
        IDLE  = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_IDX = AW'(NREGS - 1);

    logic [XLEN-1:0] mem [NREGS];

    state_t          state;
    state_t          state_next;
    logic [AW-1:0]   idx;
    logic [AW-1:0]   idx_next;
    logic            ready_next;
    logic            wr_drop_next;
    logic            write_ok;

    // A write lands only when the file is usable and it does not target a hardwired x0
    assign write_ok = we && !((ZERO_REG != 0) && (wraddr == '0));

    // State, clear index and registered status flags; reset wins over everything
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= CLEAR;
            idx     <= '0;
            ready   <= 1'b0;
            wr_drop <= 1'b0;
        end else begin
            state   <= state_next;
            idx     <= idx_next;
            ready   <= ready_next;
            wr_drop <= wr_drop_next;
        end
    end

    // Next-state logic: walk idx across the array while clearing, restart on clr
    always_comb begin
        state_next   = state;
        idx_next     = idx;
        ready_next   = ready;
        wr_drop_next = 1'b0;
        unique case (state)
            CLEAR: begin
                wr_drop_next = we;
                if (clr) begin
                    idx_next = '0;
                end else if (idx == LAST_IDX) begin
                    idx_next   = '0;
                    state_next = IDLE;
                    ready_next = 1'b1;
                end else begin
                    idx_next = idx + AW'(1);
                end
            end
            IDLE: begin
                if (clr) begin
                    state_next = CLEAR;
                    idx_next   = '0;
                    ready_next = 1'b0;
                end
            end
        endcase
    end

    // Storage update: the clear engine owns the array while clearing, otherwise the write port does
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state == CLEAR) begin
                mem[idx] <= '0;
            end else if (write_ok) begin
                mem[wraddr] <= wrdata;
            end
        end
    end

    for (genvar k = 0; k < NRD; k++) begin : g_rd
        logic [AW-1:0]   addr;
        logic [XLEN-1:0] data;

        assign addr = rs[k*AW +: AW];

        // Read mux: zero while clearing or for x0, then forwarded write data, then the array
        always_comb begin
            data = mem[addr];
            if (state == CLEAR) begin
                data = '0;
            end else if ((ZERO_REG != 0) && (addr == '0)) begin
                data = '0;
            end else if ((BYPASS != 0) && we && (wraddr == addr)) begin
                data = wrdata;
            end
        end

        assign rdout[k*XLEN +: XLEN] = data;
    end

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: drives a default-configured regfile_mp and a swept one
// (NREGS=16, NRD=4, XLEN=64, BYPASS=0) side by side against a behavioural model.
module tb_regfile_mp;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int fails  = 0;

    // Default configuration instance
    logic         rst_a = 1'b1, clr_a = 1'b0, we_a = 1'b0;
    logic [4:0]   wraddr_a = '0;
    logic [31:0]  wrdata_a = '0;
    logic [9:0]   rs_a = '0;
    logic [63:0]  rdout_a;
    logic         ready_a, wr_drop_a;

    // Swept configuration instance
    logic         rst_b = 1'b1, clr_b = 1'b0, we_b = 1'b0;
    logic [3:0]   wraddr_b = '0;
    logic [63:0]  wrdata_b = '0;
    logic [15:0]  rs_b = '0;
    logic [255:0] rdout_b;
    logic         ready_b, wr_drop_b;

    regfile_mp dut_a (
        .clk(clk), .rst(rst_a), .clr(clr_a), .ready(ready_a), .we(we_a),
        .wraddr(wraddr_a), .wrdata(wrdata_a), .rs(rs_a), .rdout(rdout_a),
        .wr_drop(wr_drop_a)
    );

    regfile_mp #(.XLEN(64), .NREGS(16), .NRD(4), .ZERO_REG(1), .BYPASS(0)) dut_b (
        .clk(clk), .rst(rst_b), .clr(clr_b), .ready(ready_b), .we(we_b),
        .wraddr(wraddr_b), .wrdata(wrdata_b), .rs(rs_b), .rdout(rdout_b),
        .wr_drop(wr_drop_b)
    );

    // Behavioural model: clear progress is "edges still to go" rather than an index
    logic [31:0] ma_mem [32];
    int          ma_left = 32;
    logic        ma_drop = 1'b0;
    logic [63:0] mb_mem [16];
    int          mb_left = 16;
    logic        mb_drop = 1'b0;

    function automatic logic [31:0] exp_a(input logic [4:0] a);
        if (ma_left > 0 || a == 5'd0) return 32'd0;
        if (we_a && wraddr_a == a) return wrdata_a;
        return ma_mem[a];
    endfunction

    function automatic logic [63:0] exp_b(input logic [3:0] a);
        if (mb_left > 0 || a == 4'd0) return 64'd0;
        return mb_mem[a];
    endfunction

    task automatic model_edge();
        if (rst_a) begin
            ma_left = 32; ma_drop = 1'b0;
        end else if (ma_left > 0) begin
            ma_mem[5'(32 - ma_left)] = 32'd0;
            ma_drop = we_a;
            ma_left = clr_a ? 32 : ma_left - 1;
        end else begin
            ma_drop = 1'b0;
            if (we_a && wraddr_a != 5'd0) ma_mem[wraddr_a] = wrdata_a;
            if (clr_a) ma_left = 32;
        end
        if (rst_b) begin
            mb_left = 16; mb_drop = 1'b0;
        end else if (mb_left > 0) begin
            mb_mem[4'(16 - mb_left)] = 64'd0;
            mb_drop = we_b;
            mb_left = clr_b ? 16 : mb_left - 1;
        end else begin
            mb_drop = 1'b0;
            if (we_b && wraddr_b != 4'd0) mb_mem[wraddr_b] = wrdata_b;
            if (clr_b) mb_left = 16;
        end
    endtask

    task automatic tick();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_a = 1'b1; rst_b = 1'b1;
        tick(); tick();
        checks++; if (ready_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready_a: got %0b want 0", ready_a); end
        checks++; if (wr_drop_a !== 1'b0) begin fails++; $display("[TB] FAIL reset_drop_a: got %0b want 0", wr_drop_a); end
        checks++; if (rdout_a !== 64'd0) begin fails++; $display("[TB] FAIL reset_rdout_a: got %h want 0", rdout_a); end
        checks++; if (ready_b !== 1'b0) begin fails++; $display("[TB] FAIL reset_ready_b: got %0b want 0", ready_b); end
        rst_a = 1'b0; rst_b = 1'b0;
        rs_a = {5'd31, 5'd7};
        rs_b = {4'd15, 4'd9, 4'd3, 4'd1};
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++; if (ready_a !== (i == 32)) begin fails++; $display("[TB] FAIL clear_ready_a edge %0d: got %0b want %0b", i, ready_a, (i == 32)); end
            checks++; if (rdout_a !== 64'd0) begin fails++; $display("[TB] FAIL clear_rdout_a edge %0d: got %h want 0", i, rdout_a); end
            checks++; if (ready_b !== (i >= 16)) begin fails++; $display("[TB] FAIL clear_ready_b edge %0d: got %0b want %0b", i, ready_b, (i >= 16)); end
        end
        for (int r = 1; r < 32; r++) begin
            rs_a[4:0] = 5'(r);
            #1;
            checks++; if (rdout_a[31:0] !== 32'd0) begin fails++; $display("[TB] FAIL post_clear x%0d: got %h want 0", r, rdout_a[31:0]); end
        end
    endtask

    task automatic test_write_read();
        we_a = 1'b1; wraddr_a = 5'd1; wrdata_a = 32'h1234_5678;
        tick();
        wraddr_a = 5'd2; wrdata_a = 32'h8765_4321;
        tick();
        we_a = 1'b0;
        rs_a = {5'd2, 5'd1};
        #1;
        checks++; if (rdout_a[31:0] !== 32'h1234_5678) begin fails++; $display("[TB] FAIL write_read x1: got %h want 12345678", rdout_a[31:0]); end
        checks++; if (rdout_a[63:32] !== 32'h8765_4321) begin fails++; $display("[TB] FAIL write_read x2: got %h want 87654321", rdout_a[63:32]); end
    endtask

    task automatic test_zero_bypass();
        we_a = 1'b1; wraddr_a = 5'd0; wrdata_a = 32'hABCD_EF01;
        rs_a = {5'd0, 5'd0};
        #1;
        checks++; if (rdout_a !== 64'd0) begin fails++; $display("[TB] FAIL x0_same_cycle: got %h want 0", rdout_a); end
        tick();
        we_a = 1'b0;
        #1;
        checks++; if (rdout_a[31:0] !== 32'd0) begin fails++; $display("[TB] FAIL x0_after: got %h want 0", rdout_a[31:0]); end
        we_a = 1'b1; wraddr_a = 5'd3; wrdata_a = 32'h5555_5555;
        rs_a = {5'd1, 5'd3};
        #1;
        checks++; if (rdout_a[31:0] !== 32'h5555_5555) begin fails++; $display("[TB] FAIL bypass_x3: got %h want 55555555", rdout_a[31:0]); end
        checks++; if (rdout_a[63:32] !== 32'h1234_5678) begin fails++; $display("[TB] FAIL bypass_other_port: got %h want 12345678", rdout_a[63:32]); end
        tick();
        we_a = 1'b0;
        #1;
        checks++; if (rdout_a[31:0] !== 32'h5555_5555) begin fails++; $display("[TB] FAIL stored_x3: got %h want 55555555", rdout_a[31:0]); end
    endtask

    task automatic test_drop();
        int n;
        we_a = 1'b1; wraddr_a = 5'd5; wrdata_a = 32'h0F0F_0F0F;
        tick();
        we_a = 1'b0; clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        checks++; if (ready_a !== 1'b0) begin fails++; $display("[TB] FAIL drop_clr_ready: got %0b want 0", ready_a); end
        repeat (8) tick();
        we_a = 1'b1; wraddr_a = 5'd5; wrdata_a = 32'hDEAD_BEEF;
        rs_a = {5'd5, 5'd5};
        #1;
        checks++; if (rdout_a !== 64'd0) begin fails++; $display("[TB] FAIL drop_read_clearing: got %h want 0", rdout_a); end
        tick();
        we_a = 1'b0;
        checks++; if (wr_drop_a !== 1'b1) begin fails++; $display("[TB] FAIL drop_pulse: got %0b want 1", wr_drop_a); end
        tick();
        checks++; if (wr_drop_a !== 1'b0) begin fails++; $display("[TB] FAIL drop_pulse_end: got %0b want 0", wr_drop_a); end
        n = 0;
        while (ready_a !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (ready_a !== 1'b1) begin fails++; $display("[TB] FAIL drop_ready_timeout: got %0b want 1", ready_a); end
        checks++; if (rdout_a[31:0] !== 32'd0) begin fails++; $display("[TB] FAIL drop_x5: got %h want 0", rdout_a[31:0]); end
    endtask

    task automatic test_restart();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        repeat (10) tick();
        clr_a = 1'b1;
        tick();
        clr_a = 1'b0;
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++; if (ready_a !== (i == 32)) begin fails++; $display("[TB] FAIL restart_ready edge %0d: got %0b want %0b", i, ready_a, (i == 32)); end
        end
    endtask

    task automatic test_rst_priority();
        rst_a = 1'b1; clr_a = 1'b1; we_a = 1'b1; wraddr_a = 5'd4; wrdata_a = 32'hCAFE_0004;
        tick();
        rst_a = 1'b0; clr_a = 1'b0; we_a = 1'b0;
        rs_a = {5'd4, 5'd1};
        #1;
        checks++; if (ready_a !== 1'b0) begin fails++; $display("[TB] FAIL rstclr_ready: got %0b want 0", ready_a); end
        checks++; if (wr_drop_a !== 1'b0) begin fails++; $display("[TB] FAIL rstclr_drop: got %0b want 0", wr_drop_a); end
        checks++; if (rdout_a !== 64'd0) begin fails++; $display("[TB] FAIL rstclr_rdout: got %h want 0", rdout_a); end
        for (int i = 1; i <= 32; i++) begin
            tick();
            checks++; if (ready_a !== (i == 32)) begin fails++; $display("[TB] FAIL rstclr_ready edge %0d: got %0b want %0b", i, ready_a, (i == 32)); end
        end
    endtask

    task automatic test_sweep();
        logic [63:0] old_v, new_v;
        logic [3:0]  a;
        for (int r = 1; r < 16; r++) begin
            we_b = 1'b1; wraddr_b = 4'(r); wrdata_b = {$urandom, $urandom};
            tick();
        end
        we_b = 1'b0;
        for (int t = 0; t < 6; t++) begin
            rs_b = 16'($urandom);
            #1;
            for (int k = 0; k < 4; k++) begin
                a = rs_b[k*4 +: 4];
                checks++; if (rdout_b[k*64 +: 64] !== exp_b(a)) begin fails++; $display("[TB] FAIL sweep_port%0d x%0d: got %h want %h", k, a, rdout_b[k*64 +: 64], exp_b(a)); end
            end
        end
        old_v = mb_mem[7];
        new_v = ~old_v;
        we_b = 1'b1; wraddr_b = 4'd7; wrdata_b = new_v;
        rs_b = {4'd7, 4'd2, 4'd1, 4'd7};
        #1;
        checks++; if (rdout_b[63:0] !== old_v) begin fails++; $display("[TB] FAIL no_forward p0: got %h want %h", rdout_b[63:0], old_v); end
        checks++; if (rdout_b[255:192] !== old_v) begin fails++; $display("[TB] FAIL no_forward p3: got %h want %h", rdout_b[255:192], old_v); end
        tick();
        we_b = 1'b0;
        #1;
        checks++; if (rdout_b[63:0] !== new_v) begin fails++; $display("[TB] FAIL next_cycle p0: got %h want %h", rdout_b[63:0], new_v); end
        checks++; if (rdout_b[255:192] !== new_v) begin fails++; $display("[TB] FAIL next_cycle p3: got %h want %h", rdout_b[255:192], new_v); end
        clr_b = 1'b1;
        tick();
        clr_b = 1'b0;
        for (int i = 1; i <= 16; i++) begin
            tick();
            checks++; if (ready_b !== (i == 16)) begin fails++; $display("[TB] FAIL sweep_clear edge %0d: got %0b want %0b", i, ready_b, (i == 16)); end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            we_a = 1'($urandom); wraddr_a = 5'($urandom); wrdata_a = $urandom;
            rs_a = 10'($urandom); clr_a = ($urandom_range(0, 49) == 0);
            we_b = 1'($urandom); wraddr_b = 4'($urandom); wrdata_b = {$urandom, $urandom};
            rs_b = 16'($urandom); clr_b = ($urandom_range(0, 49) == 0);
            if ($urandom_range(0, 3) == 0) rs_a[4:0] = wraddr_a;
            if ($urandom_range(0, 3) == 0) rs_b[3:0] = wraddr_b;
            #1;
            for (int k = 0; k < 2; k++) begin
                checks++; if (rdout_a[k*32 +: 32] !== exp_a(rs_a[k*5 +: 5])) begin fails++; $display("[TB] FAIL rand_a cyc %0d port%0d: got %h want %h", c, k, rdout_a[k*32 +: 32], exp_a(rs_a[k*5 +: 5])); end
            end
            for (int k = 0; k < 4; k++) begin
                checks++; if (rdout_b[k*64 +: 64] !== exp_b(rs_b[k*4 +: 4])) begin fails++; $display("[TB] FAIL rand_b cyc %0d port%0d: got %h want %h", c, k, rdout_b[k*64 +: 64], exp_b(rs_b[k*4 +: 4])); end
            end
            tick();
            checks++; if (ready_a !== (ma_left == 0) || wr_drop_a !== ma_drop) begin fails++; $display("[TB] FAIL rand_a_flags cyc %0d: got ready=%0b drop=%0b want ready=%0b drop=%0b", c, ready_a, wr_drop_a, (ma_left == 0), ma_drop); end
            checks++; if (ready_b !== (mb_left == 0) || wr_drop_b !== mb_drop) begin fails++; $display("[TB] FAIL rand_b_flags cyc %0d: got ready=%0b drop=%0b want ready=%0b drop=%0b", c, ready_b, wr_drop_b, (mb_left == 0), mb_drop); end
        end
        we_a = 1'b0; clr_a = 1'b0; we_b = 1'b0; clr_b = 1'b0;
    endtask

    initial begin
        $display("[TB] regfile_mp bench starting");
        test_reset();
        test_write_read();
        test_zero_bypass();
        test_drop();
        test_restart();
        test_rst_priority();
        test_sweep();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
